store_mem_controller: RTL and testbench



---
 rtl/store_mem_controller.sv | 168 ++++++++++++++++
 tb/tb_store_mem_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_mem_controller.sv
// store_mem_controller: turns one store request into word-aligned write beats with byte enables; STORE_MISALIGN_SPLIT_EN splits word-crossing SH/SW into two beats.
// Latency: first beat one cycle after acceptance, done one cycle after the last acked beat, store_err one cycle after acceptance.
// Backpressure: in_ready only in IDLE; each beat holds address/data/enables until mem_ack is sampled high.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif
`ifndef FUNCT3_WIDTH
`define FUNCT3_WIDTH 3
`endif
`ifndef OPCODE_STORE
`define OPCODE_STORE 7'b0100011
`endif

module store_mem_controller #(
  parameter int N = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [`OPCODE_WIDTH-1:0] opcode,
  input  logic [`FUNCT3_WIDTH-1:0] funct3,
  input  logic [N-1:0]             addr,
  input  logic [N-1:0]             data,
  output logic                     mem_req,
  input  logic                     mem_ack,
  output logic [N-1:0]             mem_addr,
  output logic [N-1:0]             mem_wdata,
  output logic [N/8-1:0]           mem_be,
  output logic                     done,
  output logic                     store_err
);
  localparam int BW = N / 8;
  localparam logic [`FUNCT3_WIDTH-1:0] F3_SB = `FUNCT3_WIDTH'(0);
  localparam logic [`FUNCT3_WIDTH-1:0] F3_SH = `FUNCT3_WIDTH'(1);
  localparam logic [`FUNCT3_WIDTH-1:0] F3_SW = `FUNCT3_WIDTH'(2);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, FIN} state_t;
  state_t state;

  logic [1:0]    off;
  logic [N-1:0]  base;
  logic [N-1:0]  mask;
  logic [BW-1:0] full_be;
  logic [BW-1:0] be0;
  logic [N-1:0]  wd0;
  logic          reject;
`ifdef STORE_MISALIGN_SPLIT_EN
  logic [2*BW-1:0] be_wide;
  logic [2*N-1:0]  wd_wide;
  logic [BW-1:0]   be1;
  logic [N-1:0]    wd1;
  logic [BW-1:0]   b1_be;
  logic [N-1:0]    b1_wdata;
  logic [N-1:0]    b1_addr;
`endif

  assign off      = addr[1:0];
  assign base     = {addr[N-1:2], 2'b00};
  assign in_ready = (state == IDLE);

  // Lane placement: shift the width mask and the masked data across a two-word window.
  always_comb begin
    full_be = '0;
    mask    = '0;
    reject  = 1'b1;
    case (funct3)
      F3_SB: begin
        full_be = BW'(4'b0001);
        mask    = N'(32'h0000_00FF);
        reject  = 1'b0;
      end
      F3_SH: begin
        full_be = BW'(4'b0011);
        mask    = N'(32'h0000_FFFF);
`ifdef STORE_MISALIGN_SPLIT_EN
        reject  = 1'b0;
`else
        reject  = addr[0];
`endif
      end
      F3_SW: begin
        full_be = '1;
        mask    = '1;
`ifdef STORE_MISALIGN_SPLIT_EN
        reject  = 1'b0;
`else
        reject  = (off != 2'b00);
`endif
      end
      default: ;
    endcase
`ifdef STORE_MISALIGN_SPLIT_EN
    be_wide = {{BW{1'b0}}, full_be} << off;
    wd_wide = {{N{1'b0}}, data & mask} << {off, 3'b000};
    be0     = be_wide[BW-1:0];
    be1     = be_wide[2*BW-1:BW];
    wd0     = wd_wide[N-1:0];
    wd1     = wd_wide[2*N-1:N];
`else
    be0     = full_be << off;
    wd0     = (data & mask) << {off, 3'b000};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      done      <= 1'b0;
      store_err <= 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
      b1_be     <= '0;
      b1_wdata  <= '0;
      b1_addr   <= '0;
`endif
    end else begin
      done      <= 1'b0;
      store_err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && opcode == `OPCODE_STORE) begin
            if (reject) begin
              store_err <= 1'b1;
            end else begin
              mem_req   <= 1'b1;
              mem_addr  <= base;
              mem_wdata <= wd0;
              mem_be    <= be0;
`ifdef STORE_MISALIGN_SPLIT_EN
              b1_be     <= be1;
              b1_wdata  <= wd1;
              b1_addr   <= base + N'(4);
`endif
              state     <= BEAT0;
            end
          end
        end
        BEAT0, BEAT1: begin
          if (mem_ack) begin
`ifdef STORE_MISALIGN_SPLIT_EN
            if (state == BEAT0 && b1_be != '0) begin
              mem_addr  <= b1_addr;
              mem_wdata <= b1_wdata;
              mem_be    <= b1_be;
              state     <= BEAT1;
            end else
`endif
            begin
              mem_req   <= 1'b0;
              mem_addr  <= '0;
              mem_wdata <= '0;
              mem_be    <= '0;
              done      <= 1'b1;
              state     <= FIN;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_mem_controller.sv
// Bench for store_mem_controller: randomized and directed stores checked cycle by cycle against a byte-level reference model.
module tb_store_mem_controller;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] data;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        done;
  logic        store_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  store_mem_controller #(.N(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .funct3    (funct3),
    .addr      (addr),
    .data      (data),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .done      (done),
    .store_err (store_err)
  );

  // Reference: place each stored byte at its own byte address, then group bytes by word.
  function automatic void model(input logic [6:0] op, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] d,
                                output int n, output bit err,
                                output logic [31:0] ea0, output logic [31:0] ea1,
                                output logic [31:0] ew0, output logic [31:0] ew1,
                                output logic [3:0] eb0, output logic [3:0] eb1);
    int size;
    int lane;
    logic [31:0] base;
    logic [31:0] ba;
    n = 0; err = 0;
    ew0 = '0; ew1 = '0; eb0 = '0; eb1 = '0;
    base = a & 32'hFFFF_FFFC;
    ea0 = base;
    ea1 = base + 32'd4;
    size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
    if (op != OP_STORE) return;
    if (size == 0) begin err = 1; return; end
`ifndef STORE_MISALIGN_SPLIT_EN
    if ((int'(a[1:0]) % size) != 0) begin err = 1; return; end
`endif
    for (int k = 0; k < size; k++) begin
      ba = a + 32'(k);
      lane = int'(ba[1:0]);
      if ((ba & 32'hFFFF_FFFC) == base) begin
        eb0[lane] = 1'b1;
        ew0[8*lane +: 8] = d[8*k +: 8];
      end else begin
        eb1[lane] = 1'b1;
        ew1[8*lane +: 8] = d[8*k +: 8];
      end
    end
    n = (eb1 != 4'b0000) ? 2 : 1;
  endfunction

  task automatic run_txn(input string name, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input int w);
    int n, cdone, total, bi;
    bit err, exp_req, exp_done, exp_err, exp_rdy;
    logic [31:0] ea0, ea1, ew0, ew1, xa, xw;
    logic [3:0]  eb0, eb1, xb;
    model(op, f3, a, d, n, err, ea0, ea1, ew0, ew1, eb0, eb1);
    cdone = n * (w + 1) + 1;
    total = (n > 0) ? cdone + 1 : 2;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_accept got=%b exp=1", name, in_ready);
    end
    in_valid = 1'b1; opcode = op; funct3 = f3; addr = a; data = d; mem_ack = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      opcode = 7'($urandom); funct3 = 3'($urandom); addr = $urandom; data = $urandom;
      exp_req  = (n > 0) && (c < cdone);
      exp_done = (n > 0) && (c == cdone);
      exp_err  = err && (c == 1);
      exp_rdy  = (n == 0) || (c > cdone);
      checks++;
      if (mem_req !== exp_req) begin
        errors++;
        $display("FAIL %s mem_req c=%0d got=%b exp=%b", name, c, mem_req, exp_req);
      end
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL %s done c=%0d got=%b exp=%b", name, c, done, exp_done);
      end
      checks++;
      if (store_err !== exp_err) begin
        errors++;
        $display("FAIL %s store_err c=%0d got=%b exp=%b", name, c, store_err, exp_err);
      end
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL %s in_ready c=%0d got=%b exp=%b", name, c, in_ready, exp_rdy);
      end
      if (exp_req) begin
        bi = (c - 1) / (w + 1);
        xa = (bi == 0) ? ea0 : ea1;
        xb = (bi == 0) ? eb0 : eb1;
        xw = (bi == 0) ? ew0 : ew1;
        checks++;
        if (mem_addr !== xa || mem_be !== xb || mem_wdata !== xw) begin
          errors++;
          $display("FAIL %s beat%0d c=%0d got addr=%h be=%b wdata=%h exp addr=%h be=%b wdata=%h",
                   name, bi, c, mem_addr, mem_be, mem_wdata, xa, xb, xw);
        end
      end
      if (n == 0) mem_ack = 1'($urandom % 2);
      else        mem_ack = exp_req && (((c - 1) % (w + 1)) == w);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
    opcode = '0; funct3 = '0; addr = '0; data = '0;
    #13;
    checks++;
    if ({mem_req, mem_addr, mem_wdata, mem_be, done, store_err} !== 71'd0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b addr=%h wdata=%h be=%b done=%b err=%b exp all zero",
               mem_req, mem_addr, mem_wdata, mem_be, done, store_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_sb;
    run_txn("sb_plan", OP_STORE, 3'b000, 32'h0000_0102, 32'hAABB_CCDD, 0);
  endtask

  task automatic test_split_sw;
    run_txn("sw_cross_wait3", OP_STORE, 3'b010, 32'h0000_0201, 32'h1122_3344, 3);
  endtask

  task automatic test_wrap;
    run_txn("sh_wrap", OP_STORE, 3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF, 0);
  endtask

  task automatic test_reserved;
    run_txn("reserved_f3", OP_STORE, 3'b011, 32'h0000_0200, 32'h1122_3344, 0);
  endtask

  task automatic test_load;
    run_txn("load_ignored", OP_LOAD, 3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 0);
  endtask

  task automatic test_reset_midbeat;
    @(negedge clk);
    in_valid = 1'b1; opcode = OP_STORE; funct3 = 3'b000; addr = 32'h0000_0013; data = $urandom;
    mem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL midbeat_req_before_reset got=%b exp=1", mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_be !== 4'b0000 || done !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midbeat_reset_drop got req=%b be=%b done=%b rdy=%b exp 0 0000 0 1",
               mem_req, mem_be, done, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_txn("sb_after_reset", OP_STORE, 3'b000, 32'h0000_0042, 32'h1234_5678, 1);
  endtask

  task automatic test_random;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      op = ($urandom % 8 == 0) ? OP_LOAD : OP_STORE;
      f3 = ($urandom % 6 == 0) ? 3'($urandom) : 3'($urandom % 3);
      a  = $urandom;
      if ($urandom % 5 == 0) a = 32'hFFFF_FFFC | 32'($urandom % 4);
      run_txn($sformatf("rand%0d", i), op, f3, a, $urandom, int'($urandom % 3));
    end
  endtask

  initial begin
    test_reset();
    test_sb();
    test_split_sw();
    test_wrap();
    test_reserved();
    test_load();
    test_reset_midbeat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
